// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execution-stage multiply/divide unit:
// operation encodings, FSM states and the iteration count.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } md_state_e;

    localparam int MD_ITERS = 32;

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the execution stage and the multiply/divide
// unit, including the MTHI/MTLO write port and the HI/LO read-back.
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             write_hi;
    logic             write_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opA, opB, write_hi, write_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, opA, opB, write_hi, write_lo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_core.sv
// One iteration of the unsigned datapath: shift-add multiply step or
// restoring divide step on a {upper, lower} double-width accumulator.
module mul_div_core #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        acc_next = acc;
        addend   = acc[0] ? operand : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Shifted partial remainder minus divisor; the borrow bit decides restore.
        diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (is_div) begin
            if (diff[WIDTH])
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO: latch magnitudes on
// start, iterate WIDTH times, sign-correct and commit in FIN.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITERS
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);

    md_state_e          state, state_next;
    logic [5:0]         cnt;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               done_r;

    logic               is_div_r, neg_q_r, neg_r_r, div_zero_r;
    logic [WIDTH-1:0]   a_orig_r, operand_r;
    logic [2*WIDTH-1:0] acc, acc_next;

    md_op_e             op_in;
    logic               in_div, in_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

    assign op_in     = md_op_e'(bus.op);
    assign in_div    = (op_in == MD_DIV) || (op_in == MD_DIVU);
    assign in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign a_mag     = (in_signed && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
    assign b_mag     = (in_signed && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

    mul_div_core #(.WIDTH(WIDTH)) u_core (
        .is_div   (is_div_r),
        .acc      (acc),
        .operand  (operand_r),
        .acc_next (acc_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == 6'(WIDTH - 1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign correction and the divide-by-zero override applied when committing.
    always_comb begin
        prod   = neg_q_r ? -acc : acc;
        quot   = neg_q_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_r_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_r) begin
            res_hi = div_zero_r ? a_orig_r : rem;
            res_lo = div_zero_r ? '1 : quot;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.write_hi) hi_r <= bus.wdata;
                    if (bus.write_lo) lo_r <= bus.wdata;
                end
                RUN: cnt <= cnt + 6'd1;
                FIN: begin
                    hi_r   <= res_hi;
                    lo_r   <= res_lo;
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: datapath registers have no reset; each start reloads them fully.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            is_div_r   <= in_div;
            a_orig_r   <= bus.opA;
            div_zero_r <= (bus.opB == '0);
            neg_q_r    <= in_signed && (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            neg_r_r    <= in_signed && in_div && bus.opA[WIDTH-1];
            operand_r  <= in_div ? b_mag : a_mag;
            acc        <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
        end else if (state == RUN) begin
            acc <= acc_next;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: table of hand-computed results plus
// sequences for ignored issue/writes while busy and reset mid-divide.
module tb_mul_div_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [12];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for cycle 0, then leaves the bench in cycle 1.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        step();
        bus.start = 1'b0;
    endtask

    // From cycle 1, waits (bounded) for done; returns its cycle index or -1.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.done) begin
                lat = cyc;
                break;
            end
            if (bus.busy) busy_n++;
            step();
        end
    endtask

    initial begin
        int lat, busy_n;
        logic saw_done;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIVU,  32'h0000BEEF, 32'h00000010, 32'h0000000F, 32'h00000BEE};
        vecs[4]  = '{MD_DIVU,  32'h0000BEEF, 32'h00000000, 32'h0000BEEF, 32'hFFFFFFFF};
        vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[10] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        bus.start    = 1'b0;
        bus.op       = MD_MULT;
        bus.opA      = '0;
        bus.opB      = '0;
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b0;
        bus.wdata    = '0;

        step();
        step();
        rst = 1'b0;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_hi",   bus.hi, 32'h0);
        check("reset_lo",   bus.lo, 32'h0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, busy_n);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd34);
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'd33);
            check($sformatf("v%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
            step();
            check($sformatf("v%0d_done_one_cycle", i), 32'(bus.done), 32'd0);
        end

        // Second start at cycle 10 and MTLO at cycle 12 must both be ignored.
        issue(MD_MULT, 32'h00000003, 32'h00000005);
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.start    = (cyc == 10);
            bus.op       = (cyc == 10) ? MD_DIVU : MD_MULT;
            bus.opA      = (cyc == 10) ? 32'h12345678 : 32'h00000003;
            bus.opB      = (cyc == 10) ? 32'h00000003 : 32'h00000005;
            bus.write_lo = (cyc == 12);
            bus.wdata    = 32'h0000DEAD;
            if (bus.done) begin
                lat = cyc;
                break;
            end
            step();
        end
        bus.start    = 1'b0;
        bus.write_lo = 1'b0;
        check("busy_ignore_latency", 32'(lat), 32'd34);
        check("busy_ignore_hi", bus.hi, 32'h00000000);
        check("busy_ignore_lo", bus.lo, 32'h0000000F);
        step();
        check("busy_ignore_no_second_op", 32'(bus.busy), 32'd0);

        bus.write_hi = 1'b1;
        bus.wdata    = 32'hFFFFDEAD;
        step();
        bus.write_hi = 1'b0;
        check("mthi_idle_hi", bus.hi, 32'hFFFFDEAD);
        check("mthi_idle_lo", bus.lo, 32'h0000000F);

        // Reset at cycle 15 of a DIV discards the operation.
        issue(MD_DIV, 32'h00001000, 32'h00000007);
        for (int cyc = 1; cyc < 15; cyc++) step();
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset_busy", 32'(bus.busy), 32'd0);
        check("mid_reset_hi",   bus.hi, 32'h0);
        check("mid_reset_lo",   bus.lo, 32'h0);
        saw_done = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.done || bus.busy) saw_done = 1'b1;
            step();
        end
        check("mid_reset_no_done", 32'(saw_done), 32'd0);
        check("mid_reset_lo_stable", bus.lo, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit for the MIPS execution stage, owning the architectural HI/LO registers. It consumes operand A and the post-ALUSrc operand B, the same 32-bit values the ALU adder receives, and executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles. It exposes a start/busy/done handshake so the hazard unit can stall MFHI/MFLO and new mul/div issues while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width. The iteration count equals `WIDTH`.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: request an operation. Sampled only in IDLE.
- `op`, in, 2: operation. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `opA`, in, WIDTH: multiplicand or dividend (rs).
- `opB`, in, WIDTH: multiplier or divisor (output of MuxALUSrc).
- `write_hi`, in, 1: MTHI strobe.
- `write_lo`, in, 1: MTLO strobe.
- `wdata`, in, WIDTH: MTHI/MTLO data.
- `busy`, out, 1: operation in flight (state is not IDLE).
- `done`, out, 1: one-cycle pulse; HI/LO hold the new result.
- `hi`, out, WIDTH: HI register (MFHI reads this combinationally).
- `lo`, out, WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIN.
- IDLE with `start`=1 at a clock edge:
  - latch `op`;
  - for signed ops, latch |opA| and |opB| and the result sign flags; otherwise latch raw operands;
  - clear the 6-bit iteration counter and go to RUN.
- RUN: one iteration per edge.
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring, one quotient bit per edge.
  - When the counter reaches WIDTH-1, go to FIN.
- FIN:
  - apply sign correction;
  - write HI/LO;
  - assert `done` for the following cycle;
  - go to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0]. Signed results are the two's complement of the unsigned magnitude product when the signs differ.
- Divide result: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
- Divide by zero, signed or unsigned: LO = 0xFFFFFFFF, HI = opA (original, uncorrected). Completes with the normal latency.
- 0x80000000 DIV 0xFFFFFFFF: LO = 0x80000000, HI = 0. Arithmetic wraps modulo 2^32; no trap.
- `start` while busy is ignored; there is no queueing.
- `write_hi`/`write_lo` apply only in IDLE and are ignored while busy.
- `start` and a write in the same IDLE cycle: both take effect. The write is visible until FIN overwrites HI/LO.
- `rst` (any state, including mid-RUN):
  - state goes to IDLE, counter to 0;
  - `hi` = `lo` = 0, `busy` = 0, `done` = 0;
  - the in-flight result is discarded.

## Timing
- Call the cycle in which `start` is sampled high cycle 0.
- `busy` is 1 in cycles 1..33.
- HI/LO update at the edge ending cycle 33. `done` = 1 and the new `hi`/`lo` are visible in cycle 34, with `busy` = 0 in the same cycle.
- A new `start` is accepted in cycle 34 at the earliest, so back-to-back operations run at a 34-cycle pitch.
- `hi`/`lo` are stable between operations. MTHI/MTLO are visible the cycle after the strobe.
- `done` is never high for more than one cycle.
- Output reset values: `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0.

## Structure
- Shared package `mips_pkg`:
  - `op` encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state enum IDLE/RUN/FIN;
  - constant MD_ITERS = 32.
- One sub-module: `mul_div_core`. It holds the accumulator, shift and subtract datapath for one iteration and is purely combinational, selected by multiply/divide. The top holds the FSM, counter, sign handling and HI/LO registers.

## Test plan
- MULT, opA = 0xFFFFFFFF, opB = 0x00000002 -> cycle 34: `done` = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- MULTU, same operands -> HI = 0x00000001, LO = 0xFFFFFFFE. `busy` is high for exactly 33 cycles.
- DIV, opA = 0xFFFFFFF9 (-7), opB = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU, opA = 0x0000BEEF, opB = 0x00000010 -> LO = 0x00000BEE, HI = 0x0000000F. Then DIVU 0x0000BEEF / 0 -> LO = 0xFFFFFFFF, HI = 0x0000BEEF.
- Start a MULT, pulse `start` again at cycle 10 and `write_lo` with `wdata` = 0xDEAD at cycle 12 -> both ignored; the result matches the first operation. Then `write_hi` with 0xFFFFDEAD in IDLE -> `hi` = 0xFFFFDEAD next cycle.
- Assert `rst` at cycle 15 of a DIV -> next cycle `busy` = 0, `hi` = `lo` = 0, and no `done` pulse ever appears for that DIV.
